// File: rtl/tone_gen.sv
// Square-wave tone generator: plays `note` as a half-period (clk cycles) on `speaker`, 0 = rest.
// Latency: speaker rises one edge after a sounding request; note changes take effect at period end.
// Backpressure: none; note/enable(/octave) are sampled only in IDLE or at a full-period boundary.
//
// Optional feature: define TONE_GEN_OCTAVE_EN to add the `octave` port (half = note >> octave).
module tone_gen #(
    parameter int NOTE_W   = 27,
    parameter int MIN_HALF = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note,
    input  logic              enable,
`ifdef TONE_GEN_OCTAVE_EN
    input  logic [1:0]        octave,
`endif
    output logic              speaker,
    output logic              active,
    output logic              period_done,
    output logic [NOTE_W-1:0] cur_note
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam logic [NOTE_W-1:0] ONE      = NOTE_W'(1);
    localparam logic [NOTE_W-1:0] MIN_HALF_W = NOTE_W'(MIN_HALF);

    state_t            state;
    state_t            state_nxt;
    logic [NOTE_W-1:0] cnt;
    logic [NOTE_W-1:0] cnt_nxt;
    logic [NOTE_W-1:0] cur_note_nxt;
    logic              speaker_nxt;
    logic              period_done_nxt;

    logic [NOTE_W-1:0] half;
    logic              sounding;
    logic              half_last;

    // Effective half-period of the current request and whether it should sound.
`ifdef TONE_GEN_OCTAVE_EN
    assign half = note >> octave;
`else
    assign half = note;
`endif
    assign sounding  = enable && (half >= MIN_HALF_W);

    // Last cycle of a half-period; cur_note >= MIN_HALF >= 2 in PLAY so the subtract cannot wrap.
    assign half_last = (cnt == (cur_note - ONE));

    assign active = (state == PLAY);

    // Next-state and datapath decisions; every target gets its hold/default value first.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        cur_note_nxt    = cur_note;
        speaker_nxt     = speaker;
        period_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt      = '0;
                cur_note_nxt = '0;
                speaker_nxt  = 1'b0;
                if (sounding) begin
                    cur_note_nxt = half;
                    speaker_nxt  = 1'b1;
                    state_nxt    = PLAY;
                end
            end

            PLAY: begin
                if (!half_last) begin
                    cnt_nxt = cnt + ONE;
                end else begin
                    cnt_nxt = '0;
                    if (speaker) begin
                        // End of the high phase: drop into the low phase.
                        speaker_nxt = 1'b0;
                    end else begin
                        // End of a full period: the only point a new request is adopted.
                        period_done_nxt = 1'b1;
                        if (!sounding) begin
                            state_nxt    = IDLE;
                            speaker_nxt  = 1'b0;
                            cur_note_nxt = '0;
                        end else begin
                            cur_note_nxt = half;
                            speaker_nxt  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_nxt    = IDLE;
                cnt_nxt      = '0;
                cur_note_nxt = '0;
                speaker_nxt  = 1'b0;
            end
        endcase
    end

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter, latched note and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            cur_note    <= '0;
            speaker     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            cur_note    <= cur_note_nxt;
            speaker     <= speaker_nxt;
            period_done <= period_done_nxt;
        end
    end

endmodule

// File: doc/tone_gen.md
# tone_gen

Square-wave tone generator that sits directly downstream of the recorder/player top level. It consumes the 27-bit `note` word read from note memory and drives the speaker pin with a 50%-duty square wave. `note` is the half-period in `clk` cycles; 0 means rest. Note changes are adopted only on full-period boundaries, so the speaker output never has a truncated or glitched half-cycle.

## Interface
Parameters:
- `NOTE_W`, default 27: width of the note / half-period word.
- `MIN_HALF`, default 2: smallest effective half-period that sounds; smaller values are treated as rest.

Ports:
- `clk`  input  1: system clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high reset; clears all state immediately.
- `note`  input  NOTE_W: requested half-period in `clk` cycles; 0 = rest.
- `enable`  input  1: permits sounding; 0 silences at the next period boundary.
- `speaker`  output  1: square-wave audio output.
- `active`  output  1: high while in PLAY.
- `period_done`  output  1: one-cycle pulse at each completed full period.
- `cur_note`  output  NOTE_W: half-period currently being played; 0 when idle.
- `octave`  input  2: octave raise, present only with `TONE_GEN_OCTAVE_EN` (see Configuration).

## Operation
- Effective half-period `half` = `note >> octave`, or `note` when the octave feature is absent. A request is sounding when `enable`=1 and `half` >= `MIN_HALF`.
- Internal state: `state` {IDLE, PLAY}, half-period counter `cnt` (NOTE_W bits), and latched `cur_note`.
- IDLE:
  - `speaker`=0, `active`=0, `cnt`=0, `cur_note`=0.
  - On a sounding request at an edge: `cur_note`<=`half`, `cnt`<=0, `speaker`<=1, `state`<=PLAY.
- PLAY, within a half-cycle:
  - `cnt` increments each cycle while `cnt` < `cur_note`-1.
  - When `cnt`==`cur_note`-1: `cnt`<=0 and `speaker` toggles.
- PLAY, period boundary (high-to-low toggle already done, and `cnt`==`cur_note`-1 with `speaker`=0):
  - `period_done`<=1 for one cycle.
  - Request not sounding: `state`<=IDLE, `speaker` stays 0, `cur_note`<=0.
  - Sounding and `half` != `cur_note`: `cur_note`<=`half`, `speaker`<=1.
  - Sounding and unchanged: `speaker`<=1, continue.
- `note`, `enable` and `octave` are ignored at all other times in PLAY. Mid-period changes, including rest or `enable`=0, never truncate the current period.
- `note` is in the `clk` domain, so no synchronizer is required.
- Arithmetic: `cnt` compare uses full NOTE_W width. `cur_note`-1 never underflows because `cur_note` >= `MIN_HALF` >= 2.

## Timing
- Reset values: `speaker`=0, `active`=0, `period_done`=0, `cur_note`=0, `state`=IDLE, `cnt`=0. Reset asserted mid-period forces these values immediately, with no period completion.
- Start latency: a sounding request sampled at edge k gives `speaker`=1 and `active`=1 after edge k.
- High phase lasts exactly `cur_note` cycles, low phase exactly `cur_note` cycles; full period = 2×`cur_note` cycles.
- `period_done` is high for the one cycle following the final low-phase edge.
- Back-to-back notes: the new note's high phase starts on the same edge the old period ends; there is no idle cycle.
- Stop: `speaker` remains 0 after the last full period, and `active` drops on the same edge.

## Configuration
- `TONE_GEN_OCTAVE_EN` defined:
  - Port `octave[1:0]` exists.
  - Effective half-period = `note >> octave`, evaluated only when a request is sampled.
  - A shifted result below `MIN_HALF` is treated as rest.
- `TONE_GEN_OCTAVE_EN` undefined:
  - No `octave` port.
  - `half` = `note` directly.
  - Logic is otherwise identical.

## Test plan
- Reset release, `note`=0, `enable`=1 for 100 cycles -> `speaker`=0, `active`=0, no `period_done`.
- `note`=5, `enable`=1 -> `speaker` high 5 cycles, low 5 cycles, repeating; `period_done` pulses every 10 cycles; `cur_note`=5.
- Playing `note`=5; change to `note`=3 at cycle 2 of the high phase -> current 10-cycle period completes, then 3-high/3-low periods with no gap.
- Playing `note`=4; `enable`=0 mid-high-phase -> period finishes (4 high, 4 low), then IDLE with `speaker`=0 and `active`=0. Separately, `note`=1 from IDLE -> stays silent.
- Reset asserted during the low phase of `note`=6 -> all outputs 0 immediately, without waiting for a clock edge; after release with `note`=6, a fresh period starts on the first edge.
- With `TONE_GEN_OCTAVE_EN`:
  - `note`=8, `octave`=1 -> 4-high/4-low.
  - `note`=3, `octave`=1 -> effective half-period 1 -> silent.
